tuning_word_gen: RTL

Sequential stage directly downstream of the per-digit frequency scaler. It snapshots the five scaled 24-bit frequency contributions and sums them into one output frequency in Hz. It converts that frequency into the phase-increment (tuning) word for the DDS phase accumulator using a bit-serial shift-add multiply by a fixed-point constant. The result is presented with a one-cycle valid strobe.

---
 rtl/tuning_word_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tuning_word_gen.sv
// tuning_word_gen
//   Snapshots five scaled frequency contributions, sums them, and converts the
//   total (Hz) to a DDS phase-increment word with a bit-serial shift-add
//   multiply by the fixed-point constant K, then drops FRAC fractional bits.
//   A conversion takes 33 cycles from the start edge to the valid strobe.
//
// Ports
//   clk_in     system clock
//   rst_in     synchronous active-high reset
//   start_in   conversion request, sampled only while idle
//   f0_in..f4_in  frequency contributions in Hz (FREQ_W each)
//   tw_out     tuning word, held between conversions
//   valid_out  one-cycle strobe, tw_out updated on this edge
//   busy_out   conversion in progress
//   ovf_out    last result exceeded ACC_W bits (TW_SAT_EN builds only)
//
// Build option
//   TW_SAT_EN  saturate tw_out to all ones on overflow and report ovf_out;
//              when undefined tw_out wraps modulo 2^ACC_W and ovf_out is 0.

module tuning_word_gen #(
    parameter int unsigned    FREQ_W = 24,
    parameter int unsigned    ACC_W  = 32,
    parameter int unsigned    K_W    = 32,
    parameter int unsigned    FRAC   = 16,
    parameter logic [K_W-1:0] K      = K_W'(5629500)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [FREQ_W-1:0] f0_in,
    input  logic [FREQ_W-1:0] f1_in,
    input  logic [FREQ_W-1:0] f2_in,
    input  logic [FREQ_W-1:0] f3_in,
    input  logic [FREQ_W-1:0] f4_in,
    output logic [ACC_W-1:0]  tw_out,
    output logic              valid_out,
    output logic              busy_out,
    output logic              ovf_out
);

    localparam int unsigned SUM_W  = FREQ_W + 3;
    localparam int unsigned PROD_W = SUM_W + K_W;
    localparam int unsigned IDX_W  = $clog2(SUM_W);

    localparam logic [PROD_W-1:0] K_EXT    = PROD_W'(K);
    localparam logic [IDX_W-1:0]  SUM_LAST = IDX_W'(4);
    localparam logic [IDX_W-1:0]  MUL_LAST = IDX_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [FREQ_W-1:0] f_snap [0:4];
    logic [SUM_W-1:0]  sum;
    logic [PROD_W-1:0] prod;
    logic [IDX_W-1:0]  idx;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_in)        state_nxt = S_SUM;
            S_SUM:  if (idx == SUM_LAST) state_nxt = S_MUL;
            S_MUL:  if (idx == MUL_LAST) state_nxt = S_DONE;
            S_DONE:                      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    assign busy_out = (state != S_IDLE);

    // Datapath: snapshot, accumulate, shift-add multiply, result write
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < 5; i++) begin
                f_snap[i] <= '0;
            end
            sum       <= '0;
            prod      <= '0;
            idx       <= '0;
            tw_out    <= '0;
            valid_out <= 1'b0;
`ifdef TW_SAT_EN
            ovf_out   <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        f_snap[0] <= f0_in;
                        f_snap[1] <= f1_in;
                        f_snap[2] <= f2_in;
                        f_snap[3] <= f3_in;
                        f_snap[4] <= f4_in;
                        sum       <= '0;
                        prod      <= '0;
                        idx       <= '0;
                    end
                end
                S_SUM: begin
                    sum <= sum + SUM_W'(f_snap[idx[2:0]]);
                    idx <= (idx == SUM_LAST) ? '0 : idx + 1'b1;
                end
                S_MUL: begin
                    if (sum[idx]) begin
                        prod <= prod + (K_EXT << idx);
                    end
                    idx <= (idx == MUL_LAST) ? '0 : idx + 1'b1;
                end
                S_DONE: begin
                    valid_out <= 1'b1;
`ifdef TW_SAT_EN
                    // Any bit above the ACC_W-wide window after dropping FRAC
                    // means the word does not fit.
                    if (|prod[PROD_W-1:FRAC+ACC_W]) begin
                        tw_out  <= '1;
                        ovf_out <= 1'b1;
                    end else begin
                        tw_out  <= prod[FRAC +: ACC_W];
                        ovf_out <= 1'b0;
                    end
`else
                    tw_out <= prod[FRAC +: ACC_W];
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef TW_SAT_EN
    assign ovf_out = 1'b0;
`endif

endmodule
